// File: rtl/melody_player_pkg.sv
// ============================================================================
// Module  : melody_player_pkg
// Purpose : Note codes, ROM word layout, FSM encoding and small helpers
//           shared by the melody player and its song ROM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package melody_player_pkg;

   localparam int WORD_W  = 6;
   localparam int CODE_HI = 5;
   localparam int CODE_LO = 2;
   localparam int DUR_HI  = 1;
   localparam int DUR_LO  = 0;

   localparam logic [3:0] NOTE_C4   = 4'd0;
   localparam logic [3:0] NOTE_D4   = 4'd1;
   localparam logic [3:0] NOTE_E4   = 4'd2;
   localparam logic [3:0] NOTE_F4   = 4'd3;
   localparam logic [3:0] NOTE_G4   = 4'd4;
   localparam logic [3:0] NOTE_A4   = 4'd5;
   localparam logic [3:0] NOTE_B4   = 4'd6;
   localparam logic [3:0] NOTE_C5   = 4'd7;
   localparam logic [3:0] NOTE_REST = 4'd8;
   localparam logic [3:0] NOTE_END  = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_NOTE  = 2'd2
   } state_t;

   function automatic logic [WORD_W-1:0] rom_word(input logic [3:0] code,
                                                  input logic [1:0] dur);
      return {code, dur};
   endfunction

   // Lowest-index pressed key wins; no key pressed reads as a rest.
   function automatic logic [3:0] lowest_key(input logic [7:0] keys);
      logic [3:0] code;
      code = NOTE_REST;
      for (int i = 7; i >= 0; i--) begin
         if (keys[i]) code = 4'(i);
      end
      return code;
   endfunction

endpackage

`default_nettype wire

// File: rtl/melody_rom.sv
// ============================================================================
// Module  : melody_rom
// Purpose : Synchronous-read song ROM, one registered cycle of latency.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module melody_rom
   import melody_player_pkg::*;
#(
   parameter int ADDR_W = 5
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   output logic [WORD_W-1:0] data
);

   logic [WORD_W-1:0] data_d;
   logic [WORD_W-1:0] data_q;

   // The opening phrase ends at address 3; later entries hold an alternate phrase.
   always_comb begin
      data_d = rom_word(NOTE_END, 2'd0);
      case (int'(addr))
         0:       data_d = rom_word(NOTE_C4,   2'd1);
         1:       data_d = rom_word(NOTE_REST, 2'd0);
         2:       data_d = rom_word(NOTE_G4,   2'd3);
         3:       data_d = rom_word(NOTE_END,  2'd0);
         4:       data_d = rom_word(NOTE_E4,   2'd0);
         5:       data_d = rom_word(NOTE_D4,   2'd0);
         6:       data_d = rom_word(NOTE_C4,   2'd1);
         7:       data_d = rom_word(NOTE_F4,   2'd0);
         8:       data_d = rom_word(NOTE_A4,   2'd0);
         9:       data_d = rom_word(NOTE_B4,   2'd1);
         10:      data_d = rom_word(NOTE_C5,   2'd3);
         default: data_d = rom_word(NOTE_END,  2'd0);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= data_d;
   end

   assign data = data_q;

endmodule

`default_nettype wire

// File: rtl/melody_player.sv
// ============================================================================
// Module  : melody_player
// Purpose : Plays the ROM melody on PLAY, otherwise routes a pressed key's
//           tone clock to the speaker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module melody_player
   import melody_player_pkg::*;
#(
   parameter int SONG_LEN     = 32,
   parameter int ADDR_W       = 5,
   parameter int ARTIC_CYCLES = 2500000,
   parameter int ARTIC_W      = 22
)(
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [7:0]        TONE_CLKS,
   input  logic              QUARTER_BEAT,
   input  logic              PLAY,
   input  logic              STOP,
   input  logic [7:0]        KEYS,
   output logic              SPEAKER,
   output logic              PLAYING,
   output logic              DONE,
   output logic [3:0]        NOTE_CODE,
   output logic [ADDR_W-1:0] SONG_POS
);

   logic qb_s1_q, qb_s2_q, qb_h_q, play_q;
   logic qb_s1_d, qb_s2_d, qb_h_d, play_d;
   logic tick, play_rise, last_pos;

   state_t state_q, state_d;

   logic              speaker_q, speaker_d;
   logic              done_q, done_d;
   logic [3:0]        note_code_q, note_code_d;
   logic [ADDR_W-1:0] song_pos_q, song_pos_d;
   logic [2:0]        beats_q, beats_d;
   logic [ARTIC_W-1:0] artic_q, artic_d;

   logic [WORD_W-1:0] rom_data;
   logic [3:0]        rom_code;
   logic [1:0]        rom_dur;
   logic [3:0]        key_code;

   // ROM is addressed with the next position so its word is ready in FETCH.
   melody_rom #(.ADDR_W(ADDR_W)) u_rom (
      .clk   (CLK),
      .rst_n (RESET_N),
      .addr  (song_pos_d),
      .data  (rom_data)
   );

   assign rom_code  = rom_data[CODE_HI:CODE_LO];
   assign rom_dur   = rom_data[DUR_HI:DUR_LO];
   assign key_code  = lowest_key(KEYS);
   assign tick      = qb_s2_q ^ qb_h_q;
   assign play_rise = PLAY & ~play_q;
   assign last_pos  = (song_pos_q == ADDR_W'(SONG_LEN - 1));

   always_comb begin
      qb_s1_d = QUARTER_BEAT;
      qb_s2_d = qb_s1_q;
      qb_h_d  = qb_s2_q;
      play_d  = PLAY;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         qb_s1_q <= 1'b0;
         qb_s2_q <= 1'b0;
         qb_h_q  <= 1'b0;
         play_q  <= 1'b0;
      end else begin
         qb_s1_q <= qb_s1_d;
         qb_s2_q <= qb_s2_d;
         qb_h_q  <= qb_h_d;
         play_q  <= play_d;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (STOP) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (play_rise) state_d = ST_FETCH;
            ST_FETCH: state_d = (rom_code == NOTE_END) ? ST_IDLE : ST_NOTE;
            ST_NOTE:  if (tick && beats_q == 3'd1)
                         state_d = last_pos ? ST_IDLE : ST_FETCH;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      speaker_d   = 1'b0;
      done_d      = 1'b0;
      note_code_d = note_code_q;
      song_pos_d  = song_pos_q;
      beats_d     = beats_q;
      artic_d     = artic_q;
      case (state_q)
         ST_IDLE: begin
            note_code_d = key_code;
            speaker_d   = (KEYS != 8'd0) ? TONE_CLKS[key_code[2:0]] : 1'b0;
            if (play_rise && !STOP) song_pos_d = '0;
         end
         ST_FETCH: begin
            if (!STOP) begin
               if (rom_code == NOTE_END) begin
                  done_d = 1'b1;
               end else begin
                  note_code_d = rom_code;
                  beats_d     = {1'b0, rom_dur} + 3'd1;
                  artic_d     = ARTIC_W'(ARTIC_CYCLES);
               end
            end
         end
         ST_NOTE: begin
            if (!STOP) begin
               // Silent gap at note start keeps repeated notes distinct.
               if (artic_q != '0)
                  artic_d = artic_q - ARTIC_W'(1);
               else if (!note_code_q[3])
                  speaker_d = TONE_CLKS[note_code_q[2:0]];
               if (tick) begin
                  if (beats_q == 3'd1) begin
                     if (last_pos) done_d = 1'b1;
                     else          song_pos_d = song_pos_q + ADDR_W'(1);
                  end else begin
                     beats_d = beats_q - 3'd1;
                  end
               end
            end
         end
         default: ;
      endcase
      if (STOP) speaker_d = 1'b0;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         speaker_q   <= 1'b0;
         done_q      <= 1'b0;
         note_code_q <= NOTE_REST;
         song_pos_q  <= '0;
         beats_q     <= 3'd0;
         artic_q     <= '0;
      end else begin
         speaker_q   <= speaker_d;
         done_q      <= done_d;
         note_code_q <= note_code_d;
         song_pos_q  <= song_pos_d;
         beats_q     <= beats_d;
         artic_q     <= artic_d;
      end
   end

   assign SPEAKER   = speaker_q;
   assign PLAYING   = (state_q != ST_IDLE);
   assign DONE      = done_q;
   assign NOTE_CODE = note_code_q;
   assign SONG_POS  = song_pos_q;

endmodule

`default_nettype wire

// File: tb/tb_melody_player.sv
// ============================================================================
// Module  : tb_melody_player
// Purpose : Directed self-checking bench for melody_player (piano, song,
//           last-address, STOP and reset behaviour).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_melody_player;
   import melody_player_pkg::*;

   localparam int AW = 5;

   logic          clk, rst_n, qb, play, stop;
   logic [7:0]    tone, tone_prev, keys;
   logic          spk, playing, done;
   logic [3:0]    note_code;
   logic [AW-1:0] pos;
   logic          spk2, playing2, done2;
   logic [3:0]    note_code2;
   logic [AW-1:0] pos2;

   int total = 0;
   int bad   = 0;
   int tcnt  = 0;

   typedef struct packed {
      logic [3:0]    code;
      logic [1:0]    dur;
      logic [AW-1:0] pos;
   } note_t;

   note_t exp_q[$];

   melody_player #(.SONG_LEN(32), .ADDR_W(AW), .ARTIC_CYCLES(4), .ARTIC_W(22)) u_dut (
      .CLK(clk), .RESET_N(rst_n), .TONE_CLKS(tone), .QUARTER_BEAT(qb),
      .PLAY(play), .STOP(stop), .KEYS(keys),
      .SPEAKER(spk), .PLAYING(playing), .DONE(done),
      .NOTE_CODE(note_code), .SONG_POS(pos)
   );

   // Short song length: the song must end at address 2 without reaching END.
   melody_player #(.SONG_LEN(3), .ADDR_W(AW), .ARTIC_CYCLES(4), .ARTIC_W(22)) u_short (
      .CLK(clk), .RESET_N(rst_n), .TONE_CLKS(tone), .QUARTER_BEAT(qb),
      .PLAY(play), .STOP(stop), .KEYS(keys),
      .SPEAKER(spk2), .PLAYING(playing2), .DONE(done2),
      .NOTE_CODE(note_code2), .SONG_POS(pos2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Tone clocks change 2 ns after each rising edge; tone_prev is what the DUT sampled.
   initial begin
      tone      = 8'h00;
      tone_prev = 8'h00;
      forever begin
         @(posedge clk);
         #2;
         tone_prev = tone;
         tcnt++;
         for (int i = 0; i < 8; i++)
            if (tcnt % (i + 2) == 0) tone[i] = ~tone[i];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_spk(input logic [3:0] code);
      return (code < 4'd8) ? 32'(tone_prev[code[2:0]]) : 32'd0;
   endfunction

   task automatic push_song(input int n);
      note_t nt;
      for (int i = 0; i < n; i++) begin
         case (i)
            0:       nt = '{NOTE_C4,   2'd1, AW'(0)};
            1:       nt = '{NOTE_REST, 2'd0, AW'(1)};
            default: nt = '{NOTE_G4,   2'd3, AW'(2)};
         endcase
         exp_q.push_back(nt);
      end
   endtask

   task automatic start_song();
      play = 1'b1;
      @(negedge clk);
      check("start_playing", 32'(playing), 1);
      check("start_pos", 32'(pos), 0);
      play = 1'b0;
      @(negedge clk);
   endtask

   // Entered on the first cycle of NOTE; returns 3 cycles after the final beat edge.
   task automatic do_note(input logic [3:0] code, input logic [1:0] dur, input logic [AW-1:0] p);
      check("note_code", 32'(note_code), 32'(code));
      check("note_pos", 32'(pos), 32'(p));
      check("note_playing", 32'(playing), 1);
      for (int i = 0; i < 5; i++) begin
         check("artic_silent", 32'(spk), 0);
         @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         check("note_tone", 32'(spk), exp_spk(code));
         @(negedge clk);
      end
      for (int b = 0; b <= int'(dur); b++) begin
         qb = ~qb;
         if (b < int'(dur)) begin
            repeat (10) @(negedge clk);
            check("beat_hold_pos", 32'(pos), 32'(p));
            check("beat_hold_code", 32'(note_code), 32'(code));
            check("beat_hold_tone", 32'(spk), exp_spk(code));
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic run_queue();
      note_t n;
      while (exp_q.size() > 0) begin
         n = exp_q.pop_front();
         do_note(n.code, n.dur, n.pos);
         if (exp_q.size() > 0) begin
            check("advance_pos", 32'(pos), 32'(n.pos) + 1);
            check("advance_playing", 32'(playing), 1);
            @(negedge clk);
         end
      end
   endtask

   initial begin
      rst_n = 1'b1; qb = 1'b0; play = 1'b0; stop = 1'b0; keys = 8'h00;
      #3 rst_n = 1'b0;
      #3;
      check("rst_spk", 32'(spk), 0);
      check("rst_playing", 32'(playing), 0);
      check("rst_done", 32'(done), 0);
      check("rst_code", 32'(note_code), 8);
      check("rst_pos", 32'(pos), 0);
      check("rst_short_pos", 32'(pos2), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Piano mode
      keys = 8'b0000_0100;
      @(negedge clk);
      repeat (12) begin
         check("piano_code_e", 32'(note_code), 2);
         check("piano_spk_e", 32'(spk), 32'(tone_prev[2]));
         check("piano_playing", 32'(playing), 0);
         @(negedge clk);
      end
      keys = 8'b1000_0100;
      @(negedge clk);
      repeat (8) begin
         check("piano_lowest_code", 32'(note_code), 2);
         check("piano_lowest_spk", 32'(spk), 32'(tone_prev[2]));
         @(negedge clk);
      end
      keys = 8'b1000_0000;
      @(negedge clk);
      repeat (10) begin
         check("piano_c5_code", 32'(note_code), 7);
         check("piano_c5_spk", 32'(spk), 32'(tone_prev[7]));
         @(negedge clk);
      end
      keys = 8'h00;
      @(negedge clk);
      repeat (4) begin
         check("piano_none_code", 32'(note_code), 8);
         check("piano_none_spk", 32'(spk), 0);
         @(negedge clk);
      end

      // Full song to END; the short instance ends at its last address
      push_song(3);
      start_song();
      run_queue();
      check("end_fetch_pos", 32'(pos), 3);
      check("end_fetch_playing", 32'(playing), 1);
      check("end_fetch_done", 32'(done), 0);
      check("last_done", 32'(done2), 1);
      check("last_playing", 32'(playing2), 0);
      check("last_pos", 32'(pos2), 2);
      @(negedge clk);
      check("end_done", 32'(done), 1);
      check("end_playing", 32'(playing), 0);
      check("end_pos", 32'(pos), 3);
      check("last_done_once", 32'(done2), 0);
      check("last_no_wrap", 32'(pos2), 2);
      @(negedge clk);
      check("end_done_once", 32'(done), 0);
      check("end_pos_hold", 32'(pos), 3);
      check("end_idle_code", 32'(note_code), 8);

      // STOP during G
      push_song(2);
      start_song();
      run_queue();
      check("stop_pre_pos", 32'(pos), 2);
      @(negedge clk);
      check("stop_g_code", 32'(note_code), 4);
      repeat (8) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      check("stop_playing", 32'(playing), 0);
      check("stop_spk", 32'(spk), 0);
      check("stop_done", 32'(done), 0);
      check("stop_short_done", 32'(done2), 0);
      @(negedge clk);
      check("stop_idle_code", 32'(note_code), 8);
      play = 1'b1;
      repeat (3) @(negedge clk);
      check("stop_play_ignored", 32'(playing), 0);
      stop = 1'b0;
      repeat (3) @(negedge clk);
      check("stop_release_idle", 32'(playing), 0);
      play = 1'b0;
      @(negedge clk);

      // Asynchronous reset during G
      push_song(2);
      start_song();
      run_queue();
      @(negedge clk);
      check("rst_mid_g_code", 32'(note_code), 4);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_code", 32'(note_code), 8);
      check("rst_mid_pos", 32'(pos), 0);
      check("rst_mid_playing", 32'(playing), 0);
      check("rst_mid_spk", 32'(spk), 0);
      check("rst_mid_done", 32'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         qb = ~qb;
         repeat (10) @(negedge clk);
         check("rst_no_resume", 32'(playing), 0);
         check("rst_no_resume_pos", 32'(pos), 0);
      end
      push_song(1);
      start_song();
      run_queue();
      check("replay_advance", 32'(pos), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
